pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage RV64 pipeline (IF/ID/EXE/MEM/WB).
- Resolves load-use hazards, multicycle EXE units, D-cache and I-cache waits, EXE branch redirects and MEM traps.
- Drives per-pipeline-register stall/flush and the PC redirect to IF.
- Holds a redirect pending while IF is mid-refill. Keeps hazard statistics counters.

Parameters:
- XLEN, 64, PC/target width
- CNT_W, 32, width of each statistics counter

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- id_rs1_en  in  1  ID instruction reads rs1
- id_rs2_en  in  1  ID instruction reads rs2
- id_rs1  in  5  ID rs1 index
- id_rs2  in  5  ID rs2 index
- exe_rd_en  in  1  EXE instruction writes rd
- exe_rd  in  5  EXE rd index
- exe_mem_read  in  1  EXE instruction is a load
- exe_busy  in  1  multicycle EXE unit (mul/div) not finished
- mem_busy  in  1  D-cache access not finished
- if_busy  in  1  I-cache refill in progress; IF cannot take a new PC
- br_redirect  in  1  EXE resolved mispredict/jump
- br_target  in  XLEN  EXE redirect PC
- trap_valid  in  1  MEM-stage exception/interrupt taken
- trap_target  in  XLEN  trap vector PC
- if_id_stall, id_exe_stall, exe_mem_stall  out  1 each  hold pipeline register
- if_id_flush, id_exe_flush, exe_mem_flush, mem_wb_flush  out  1 each  load bubble into register
- pc_redirect  out  1  IF loads pc_target this cycle
- pc_target  out  XLEN  redirect PC
- stall_cnt, loaduse_cnt, redirect_cnt  out  CNT_W each  statistics

Behaviour:
- State machine with 2 states:
  - RUN
  - WAIT_IF: redirect pending; registers pend_target.
- Reset: state RUN, pend_target 0, all counters 0. Stalls/flushes/pc_redirect combinational and 0 when rst is high.
- Hazard definition:
  - load_use = exe_mem_read & exe_rd_en & exe_rd!=0 & ((id_rs1_en & id_rs1==exe_rd) | (id_rs2_en & id_rs2==exe_rd)).
  - x0 never hazards.
- Per-cycle priority (highest first; only the first matching row applies):
  1. mem_busy: all three stalls = 1; mem_wb_flush = 1; no redirect.
     - A trap or branch presented this cycle is not consumed; sources must hold it.
  2. trap_valid:
     - Flush if_id, id_exe, exe_mem; mem_wb_flush = 1 (trapping instruction does not retire).
     - Redirect to trap_target. Overrides a pending branch redirect.
  3. exe_busy: if_id_stall = 1, id_exe_stall = 1; exe_mem_flush = 1.
     - br_redirect is ignored until exe_busy = 0.
  4. br_redirect: if_id_flush = 1, id_exe_flush = 1; redirect to br_target.
  5. load_use: if_id_stall = 1; id_exe_flush = 1.
  6. Otherwise: all outputs 0.
- Redirect application:
  - If a redirect arises (rows 2/4) and if_busy = 0 in RUN: pc_redirect = 1 with that target, same cycle.
  - If if_busy = 1: capture target into pend_target and go to WAIT_IF.
- WAIT_IF:
  - if_id_flush = 1 every cycle, so wrong-path fetches never enter ID.
  - When if_busy falls: pc_redirect = 1, pc_target = pend_target, go to RUN.
  - A trap in WAIT_IF overwrites pend_target (trap wins).
  - A new br_redirect in WAIT_IF is impossible (wrong-path instruction is already flushed); it is ignored.
  - mem_busy in WAIT_IF still freezes the pipe; if_busy falling in that same cycle still fires pc_redirect. IF is independent of the back-end freeze.
- pc_redirect is high for exactly one cycle per redirect event.
- Counters (saturate at all-ones, no wrap):
  - stall_cnt += 1 on any cycle with if_id_stall.
  - loaduse_cnt += 1 on cycles where row 5 applies.
  - redirect_cnt += 1 per pc_redirect pulse.
- Reset mid-WAIT_IF drops the pending redirect.

Test Plan:
- Load-use: EXE load rd=5, ID rs2=5 (rs2_en=1) → one cycle with if_id_stall=1, id_exe_flush=1; loaduse_cnt 0→1. With rd=0 → no stall.
- Multicycle div: exe_busy high 4 cycles → if_id_stall=id_exe_stall=exe_mem_flush=1 for exactly 4 cycles; stall_cnt=4. br_redirect asserted during that window has no effect until cycle 5.
- Branch, IF idle: br_redirect, br_target=0x8000_0100 → same-cycle pc_redirect=1, pc_target=0x8000_0100, if_id_flush=id_exe_flush=1.
- Branch during refill: br_redirect with if_busy high 3 more cycles → WAIT_IF; if_id_flush high each cycle; single pc_redirect when if_busy drops, target held.
- Trap vs branch vs dcache: trap_valid and br_redirect together with mem_busy=1 → full freeze, no redirect. Next cycle with mem_busy=0 → trap wins: pc_target=trap_target=0x8000_0004, four flushes asserted, redirect_cnt +1.
- Reset in WAIT_IF: rst pulse → RUN, counters 0, no pc_redirect when if_busy later falls.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline, with PC redirect and hazard statistics.
// Latency: stall/flush/redirect outputs are combinational in the same cycle; a redirect is deferred while IF refills.
// Backpressure: mem_busy freezes the back-end and consumes nothing; if_busy defers a redirect into WAIT_IF.
module pipe_hazard_ctrl #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_rs1_en,
  input  logic             id_rs2_en,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             exe_rd_en,
  input  logic [4:0]       exe_rd,
  input  logic             exe_mem_read,
  input  logic             exe_busy,
  input  logic             mem_busy,
  input  logic             if_busy,
  input  logic             br_redirect,
  input  logic [XLEN-1:0]  br_target,
  input  logic             trap_valid,
  input  logic [XLEN-1:0]  trap_target,
  output logic             if_id_stall,
  output logic             id_exe_stall,
  output logic             exe_mem_stall,
  output logic             if_id_flush,
  output logic             id_exe_flush,
  output logic             exe_mem_flush,
  output logic             mem_wb_flush,
  output logic             pc_redirect,
  output logic [XLEN-1:0]  pc_target,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] loaduse_cnt,
  output logic [CNT_W-1:0] redirect_cnt
);

  localparam logic [0:0] S_RUN     = 1'b0;
  localparam logic [0:0] S_WAIT_IF = 1'b1;

  logic [0:0]      state_q;
  logic [0:0]      state_d;
  logic [XLEN-1:0] pend_target_q;
  logic [XLEN-1:0] pend_target_d;
  logic            load_use;
  logic            load_use_row;
  logic            redir_req;
  logic [XLEN-1:0] redir_tgt;
  logic [XLEN-1:0] wait_tgt;

  // x0 is hardwired zero, so a load targeting it can never create a dependency
  assign load_use = exe_mem_read & exe_rd_en & (exe_rd != 5'd0) &
                    ((id_rs1_en & (id_rs1 == exe_rd)) | (id_rs2_en & (id_rs2 == exe_rd)));

  // Priority resolution of hazards, then redirect application against IF availability
  always_comb begin
    if_id_stall   = 1'b0;
    id_exe_stall  = 1'b0;
    exe_mem_stall = 1'b0;
    if_id_flush   = 1'b0;
    id_exe_flush  = 1'b0;
    exe_mem_flush = 1'b0;
    mem_wb_flush  = 1'b0;
    pc_redirect   = 1'b0;
    pc_target     = '0;
    load_use_row  = 1'b0;
    redir_req     = 1'b0;
    redir_tgt     = '0;
    wait_tgt      = '0;
    state_d       = state_q;
    pend_target_d = pend_target_q;
    if (!rst) begin
      if (mem_busy) begin
        // D-cache wait freezes everything; trap/branch stay with their sources
        if_id_stall   = 1'b1;
        id_exe_stall  = 1'b1;
        exe_mem_stall = 1'b1;
        mem_wb_flush  = 1'b1;
      end else if (trap_valid) begin
        // Trapping instruction and everything younger is squashed
        if_id_flush   = 1'b1;
        id_exe_flush  = 1'b1;
        exe_mem_flush = 1'b1;
        mem_wb_flush  = 1'b1;
        redir_req     = 1'b1;
        redir_tgt     = trap_target;
      end else if (exe_busy) begin
        // Branch resolution waits for the multicycle unit to finish
        if_id_stall   = 1'b1;
        id_exe_stall  = 1'b1;
        exe_mem_flush = 1'b1;
      end else if (br_redirect && (state_q == S_RUN)) begin
        // In WAIT_IF a branch can only come from an already-flushed wrong path
        if_id_flush   = 1'b1;
        id_exe_flush  = 1'b1;
        redir_req     = 1'b1;
        redir_tgt     = br_target;
      end else if (load_use) begin
        if_id_stall   = 1'b1;
        id_exe_flush  = 1'b1;
        load_use_row  = 1'b1;
      end

      if (state_q == S_RUN) begin
        if (redir_req) begin
          if (!if_busy) begin
            pc_redirect = 1'b1;
            pc_target   = redir_tgt;
          end else begin
            pend_target_d = redir_tgt;
            state_d       = S_WAIT_IF;
          end
        end
      end else begin
        // Keep wrong-path fetches out of ID until the redirect lands
        if_id_flush = 1'b1;
        wait_tgt    = redir_req ? redir_tgt : pend_target_q;
        if (!if_busy) begin
          pc_redirect = 1'b1;
          pc_target   = wait_tgt;
          state_d     = S_RUN;
        end else begin
          pend_target_d = wait_tgt;
        end
      end
    end
  end

  // State and pending redirect target; reset drops any pending redirect
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_RUN;
      pend_target_q <= '0;
    end else begin
      state_q       <= state_d;
      pend_target_q <= pend_target_d;
    end
  end

  // Saturating hazard statistics
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt    <= '0;
      loaduse_cnt  <= '0;
      redirect_cnt <= '0;
    end else begin
      if (if_id_stall && (stall_cnt != '1))
        stall_cnt <= stall_cnt + 1'b1;
      if (load_use_row && (loaduse_cnt != '1))
        loaduse_cnt <= loaduse_cnt + 1'b1;
      if (pc_redirect && (redirect_cnt != '1))
        redirect_cnt <= redirect_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

  localparam int XLEN  = 64;
  localparam int CNT_W = 8;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst;
  logic             id_rs1_en, id_rs2_en;
  logic [4:0]       id_rs1, id_rs2;
  logic             exe_rd_en;
  logic [4:0]       exe_rd;
  logic             exe_mem_read, exe_busy, mem_busy, if_busy;
  logic             br_redirect, trap_valid;
  logic [XLEN-1:0]  br_target, trap_target;
  logic             if_id_stall, id_exe_stall, exe_mem_stall;
  logic             if_id_flush, id_exe_flush, exe_mem_flush, mem_wb_flush;
  logic             pc_redirect;
  logic [XLEN-1:0]  pc_target;
  logic [CNT_W-1:0] stall_cnt, loaduse_cnt, redirect_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit              m_pend;
  logic [XLEN-1:0] m_ptgt;
  int              m_stall, m_lu, m_rd;

  pipe_hazard_ctrl #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .id_rs1_en(id_rs1_en), .id_rs2_en(id_rs2_en), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .exe_rd_en(exe_rd_en), .exe_rd(exe_rd), .exe_mem_read(exe_mem_read),
    .exe_busy(exe_busy), .mem_busy(mem_busy), .if_busy(if_busy),
    .br_redirect(br_redirect), .br_target(br_target),
    .trap_valid(trap_valid), .trap_target(trap_target),
    .if_id_stall(if_id_stall), .id_exe_stall(id_exe_stall), .exe_mem_stall(exe_mem_stall),
    .if_id_flush(if_id_flush), .id_exe_flush(id_exe_flush), .exe_mem_flush(exe_mem_flush),
    .mem_wb_flush(mem_wb_flush), .pc_redirect(pc_redirect), .pc_target(pc_target),
    .stall_cnt(stall_cnt), .loaduse_cnt(loaduse_cnt), .redirect_cnt(redirect_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    id_rs1_en = 0; id_rs2_en = 0; id_rs1 = 0; id_rs2 = 0;
    exe_rd_en = 0; exe_rd = 0; exe_mem_read = 0; exe_busy = 0;
    mem_busy = 0; if_busy = 0; br_redirect = 0; trap_valid = 0;
    br_target = '0; trap_target = '0;
  endtask

  function automatic int sat(input int v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  // One cycle: compare against the model, clock, advance the model
  task automatic step();
    int       row;
    bit       lu, have, fire;
    bit [6:0] pat;
    logic [XLEN-1:0] tgt;
    #2;
    lu = exe_mem_read && exe_rd_en && exe_rd != 0 &&
         ((id_rs1_en && id_rs1 == exe_rd) || (id_rs2_en && id_rs2 == exe_rd));
    if (mem_busy)                     row = 1;
    else if (trap_valid)              row = 2;
    else if (exe_busy)                row = 3;
    else if (br_redirect && !m_pend)  row = 4;
    else if (lu)                      row = 5;
    else                              row = 6;
    // {ifid_st, idexe_st, exemem_st, ifid_fl, idexe_fl, exemem_fl, memwb_fl}
    case (row)
      1: pat = 7'b1110001;
      2: pat = 7'b0001111;
      3: pat = 7'b1100010;
      4: pat = 7'b0001100;
      5: pat = 7'b1000100;
      default: pat = 7'b0000000;
    endcase
    if (m_pend) pat[3] = 1'b1;
    have = 0; tgt = '0;
    if (row == 2)      begin have = 1; tgt = trap_target; end
    else if (row == 4) begin have = 1; tgt = br_target; end
    else if (m_pend)   begin have = 1; tgt = m_ptgt; end
    fire = have && !if_busy;
    if (rst) begin pat = '0; fire = 0; end
    check("if_id_stall",   if_id_stall,   pat[6]);
    check("id_exe_stall",  id_exe_stall,  pat[5]);
    check("exe_mem_stall", exe_mem_stall, pat[4]);
    check("if_id_flush",   if_id_flush,   pat[3]);
    check("id_exe_flush",  id_exe_flush,  pat[2]);
    check("exe_mem_flush", exe_mem_flush, pat[1]);
    check("mem_wb_flush",  mem_wb_flush,  pat[0]);
    check("pc_redirect",   pc_redirect,   fire);
    if (fire) check("pc_target", pc_target, tgt);
    check("stall_cnt",    stall_cnt,    m_stall);
    check("loaduse_cnt",  loaduse_cnt,  m_lu);
    check("redirect_cnt", redirect_cnt, m_rd);
    @(posedge clk);
    if (rst) begin
      m_pend = 0; m_ptgt = '0; m_stall = 0; m_lu = 0; m_rd = 0;
    end else begin
      if (pat[6])   m_stall = sat(m_stall);
      if (row == 5) m_lu    = sat(m_lu);
      if (fire)     m_rd    = sat(m_rd);
      m_pend = have && if_busy;
      if (m_pend) m_ptgt = tgt;
    end
    #1;
  endtask

  initial begin
    m_pend = 0; m_ptgt = '0; m_stall = 0; m_lu = 0; m_rd = 0;
    idle_inputs();
    rst = 1;
    step(); step();
    rst = 0;
    step();
    check("reset_stall_cnt", stall_cnt, 0);
    check("reset_redirect_cnt", redirect_cnt, 0);

    // Load-use on rs2, then the same with rd = x0
    exe_mem_read = 1; exe_rd_en = 1; exe_rd = 5; id_rs2_en = 1; id_rs2 = 5;
    step();
    idle_inputs(); step();
    check("loaduse_cnt_after_lu", loaduse_cnt, 1);
    exe_mem_read = 1; exe_rd_en = 1; exe_rd = 0; id_rs2_en = 1; id_rs2 = 0;
    step();
    idle_inputs(); step();
    check("loaduse_cnt_x0", loaduse_cnt, 1);

    // Divider busy 4 cycles, branch held from cycle 3, taken in cycle 5
    for (int i = 0; i < 4; i++) begin
      exe_busy = 1;
      br_redirect = (i >= 2); br_target = 64'h8000_0200;
      step();
    end
    check("stall_cnt_div", stall_cnt, 5);
    check("redirect_cnt_div", redirect_cnt, 0);
    exe_busy = 0; step();
    idle_inputs(); step();
    check("redirect_cnt_after_div", redirect_cnt, 1);

    // Branch with IF idle
    br_redirect = 1; br_target = 64'h8000_0100;
    step();
    idle_inputs(); step();

    // Branch during refill: IF busy 3 more cycles
    br_redirect = 1; br_target = 64'h8000_0300; if_busy = 1;
    step();
    br_redirect = 0; br_target = '0;
    step(); step(); step();
    if_busy = 0; step();
    step();
    check("redirect_cnt_refill", redirect_cnt, 3);

    // Trap + branch under D-cache wait, then trap wins
    trap_valid = 1; trap_target = 64'h8000_0004;
    br_redirect = 1; br_target = 64'h8000_0500; mem_busy = 1;
    step();
    mem_busy = 0; step();
    idle_inputs(); step();
    check("redirect_cnt_trap", redirect_cnt, 4);

    // Reset while a redirect is pending
    br_redirect = 1; br_target = 64'h8000_0600; if_busy = 1;
    step();
    br_redirect = 0; step();
    rst = 1; step();
    rst = 0; step();
    if_busy = 0; step();
    check("redirect_cnt_post_rst", redirect_cnt, 0);

    // Randomized traffic checked against the model
    for (int n = 0; n < 4000; n++) begin
      rst          = ($urandom_range(999) == 0);
      mem_busy     = ($urandom_range(4) == 0);
      trap_valid   = ($urandom_range(9) == 0);
      exe_busy     = ($urandom_range(5) == 0);
      br_redirect  = ($urandom_range(5) == 0);
      if_busy      = ($urandom_range(2) == 0);
      exe_mem_read = $urandom_range(1);
      exe_rd_en    = $urandom_range(1);
      id_rs1_en    = $urandom_range(1);
      id_rs2_en    = $urandom_range(1);
      exe_rd       = 5'($urandom_range(3));
      id_rs1       = 5'($urandom_range(3));
      id_rs2       = 5'($urandom_range(3));
      br_target    = {$urandom, $urandom};
      trap_target  = {$urandom, $urandom};
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
